systolic_mm_engine: RTL and testbench

Parametrised output-stationary systolic matrix-multiply engine: computes C = A·B for a ROWS×K by K×COLS operand pair with runtime K. The engine inserts its own input skew, accumulates in place, and drains results row by row over a valid/ready port. It is the next-generation replacement for the fixed 32-bit, free-running PE grid in the TPU datapath. It adds configurable widths, signed/unsigned mode, a start/done controller and a backpressured drain.

---
 rtl/systolic_mm_engine.sv | 186 ++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_engine.sv
// Output-stationary systolic C = A*B engine with built-in operand skew and runtime inner dimension K.
// Latency: first result row K + ROWS + COLS cycles after start (plus one per idle feed cycle); one row per cycle after.
// Backpressure: in_ready only while feeding; drain row and data hold until out_ready, nothing is lost.
module systolic_mm_engine #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int AW   = 32,
    parameter int KW   = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [KW-1:0]                                k_len,
    input  logic                                         signed_mode,
    output logic                                         busy,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [ROWS*DW-1:0]                           a_data,
    input  logic [COLS*DW-1:0]                           b_data,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]   out_row,
    output logic [COLS*AW-1:0]                           out_data,
    output logic                                         out_last,
    output logic                                         done
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FW = $clog2(ROWS + COLS);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;
    state_t state, state_nxt;

    logic [KW-1:0]      klen_q, kc;
    logic [FW-1:0]      fc;
    logic               sgn, beat, hs, clr, shift, row_last;
    logic [DW-1:0]      a_inj [ROWS];
    logic [DW-1:0]      b_inj [COLS];
    logic [DW-1:0]      a_bus [ROWS][COLS+1];
    logic [DW-1:0]      b_bus [ROWS+1][COLS];
    logic [AW-1:0]      acc   [ROWS][COLS];
    logic [RW-1:0]      row_sel;
    logic [COLS*AW-1:0] row_dat;

    assign row_last  = (out_row == RW'(ROWS - 1));
    assign clr       = (state == IDLE) && start;
    assign shift     = (state == FEED) || (state == FLUSH);
    assign busy      = (state != IDLE);
    assign in_ready  = (state == FEED);
    assign out_valid = (state == DRAIN);
    assign out_last  = out_valid && row_last;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        beat      = 1'b0;
        hs        = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = (k_len == '0) ? DRAIN : FEED;
            FEED: begin
                beat = in_valid;
                if (in_valid && (kc + KW'(1)) == klen_q) state_nxt = FLUSH;
            end
            FLUSH: if (fc == FW'(ROWS + COLS - 2)) state_nxt = DRAIN;
            DRAIN: begin
                hs = out_ready;
                if (out_ready && row_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Cycles without a beat push zeros, so gaps travel through the array as harmless bubbles.
    always_comb begin
        for (int i = 0; i < ROWS; i++) a_inj[i] = beat ? a_data[i*DW +: DW] : '0;
        for (int j = 0; j < COLS; j++) b_inj[j] = beat ? b_data[j*DW +: DW] : '0;
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_askew
        if (i == 0) begin : g_direct
            assign a_bus[0][0] = a_inj[0];
        end else begin : g_line
            logic [DW-1:0] line [i];
            always_ff @(posedge clk) begin
                if (!rst || clr) begin
                    for (int k = 0; k < i; k++) line[k] <= '0;
                end else if (shift) begin
                    line[0] <= a_inj[i];
                    for (int k = 1; k < i; k++) line[k] <= line[k-1];
                end
            end
            assign a_bus[i][0] = line[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_bskew
        if (j == 0) begin : g_direct
            assign b_bus[0][0] = b_inj[0];
        end else begin : g_line
            logic [DW-1:0] line [j];
            always_ff @(posedge clk) begin
                if (!rst || clr) begin
                    for (int k = 0; k < j; k++) line[k] <= '0;
                end else if (shift) begin
                    line[0] <= b_inj[j];
                    for (int k = 1; k < j; k++) line[k] <= line[k-1];
                end
            end
            assign b_bus[0][j] = line[j-1];
        end
    end

    // One extra operand bit selects signed/unsigned; the exact product is then wrapped into AW bits.
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_pe
            logic [DW-1:0]           a_q, b_q;
            logic [AW-1:0]           acc_q;
            logic signed [DW:0]      ax, bx;
            logic signed [2*DW+1:0]  prod;

            assign ax   = {sgn & a_bus[i][j][DW-1], a_bus[i][j]};
            assign bx   = {sgn & b_bus[i][j][DW-1], b_bus[i][j]};
            assign prod = ax * bx;

            always_ff @(posedge clk) begin
                if (!rst || clr) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else if (shift) begin
                    a_q   <= a_bus[i][j];
                    b_q   <= b_bus[i][j];
                    acc_q <= acc_q + AW'(prod);
                end
            end

            assign a_bus[i][j+1] = a_q;
            assign b_bus[i+1][j] = b_q;
            assign acc[i][j]     = acc_q;
        end
    end

    always_comb begin
        row_sel = (state == FLUSH) ? '0 : out_row + RW'(1);
        row_dat = '0;
        for (int j = 0; j < COLS; j++) row_dat[j*AW +: AW] = acc[row_sel][j];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            klen_q   <= '0;
            sgn      <= 1'b0;
            kc       <= '0;
            fc       <= '0;
            out_row  <= '0;
            out_data <= '0;
            done     <= 1'b0;
        end else begin
            done <= hs && row_last;
            if (clr) begin
                klen_q   <= k_len;
                sgn      <= signed_mode;
                kc       <= '0;
                fc       <= '0;
                out_row  <= '0;
                out_data <= '0;
            end
            if (beat) kc <= kc + KW'(1);
            if (state == FLUSH) fc <= fc + FW'(1);
            if (state == FLUSH && state_nxt == DRAIN) out_data <= row_dat;
            if (hs) begin
                if (row_last) begin
                    out_row  <= '0;
                    out_data <= '0;
                end else begin
                    out_row  <= out_row + RW'(1);
                    out_data <= row_dat;
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Randomised bench for systolic_mm_engine: a matrix-level model predicts every output cycle by cycle.
module tb_systolic_mm_engine;
    localparam int R = 4, C = 4, DW = 8, AW = 32, AW2 = 16, KW = 8, KMAX = 16;

    logic            clk = 1'b0, rst = 1'b0, start = 1'b0, signed_mode = 1'b0;
    logic            in_valid = 1'b0, out_ready = 1'b1;
    logic [KW-1:0]   k_len = '0;
    logic [R*DW-1:0] a_data = '0;
    logic [C*DW-1:0] b_data = '0;
    logic            busy, in_ready, out_valid, out_last, done;
    logic [1:0]      out_row;
    logic [C*AW-1:0] out_data;
    logic            busy16, in_ready16, out_valid16, out_last16, done16;
    logic [1:0]      out_row16;
    logic [C*AW2-1:0] out_data16;

    systolic_mm_engine #(.ROWS(R), .COLS(C), .DW(DW), .AW(AW), .KW(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .signed_mode(signed_mode),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_data(out_data),
        .out_last(out_last), .done(done));

    systolic_mm_engine #(.ROWS(R), .COLS(C), .DW(DW), .AW(AW2), .KW(KW)) dut16 (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .signed_mode(signed_mode),
        .busy(busy16), .in_valid(in_valid), .in_ready(in_ready16), .a_data(a_data), .b_data(b_data),
        .out_valid(out_valid16), .out_ready(out_ready), .out_row(out_row16), .out_data(out_data16),
        .out_last(out_last16), .done(done16));

    always #5 clk = ~clk;

    int     nvec = 0, nerr = 0;
    int     ma [R][KMAX];
    int     mb [KMAX][C];
    longint mc [R][C];
    int     j_k = 0, j_l = 0;
    bit     m_active = 1'b0, m_done = 1'b0, m_post_rst = 1'b1;
    int     m_c = 0, m_row = 0, m_drain = 0;
    logic [AW-1:0]  obs   [R][C];
    logic [AW2-1:0] obs16 [R][C];
    int     obs_cnt [R];
    int     first_valid_c = -1, done_c = -1;
    int     bp_mode = 0, held = 0;
    bit     start_pulsed = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] trunc(input longint v, input int w);
        return v & ((64'd1 << w) - 64'd1);
    endfunction

    function automatic longint opval(input int v, input bit s);
        return (s && v >= 128) ? longint'(v - 256) : longint'(v);
    endfunction

    task automatic compute_model(input int k, input bit s);
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                longint sum = 0;
                for (int kk = 0; kk < k; kk++) sum += opval(ma[i][kk], s) * opval(mb[kk][j], s);
                mc[i][j] = sum;
            end
    endtask

    // Expected behaviour per cycle: a job is a feed window of L cycles, then rows from cycle L+R+C.
    always @(negedge clk) begin
        bit ev, er;
        ev = m_active && (m_c >= m_drain);
        er = m_active && (j_k != 0) && (m_c >= 1) && (m_c <= j_l);
        chk("busy", busy, m_active);
        chk("busy16", busy16, m_active);
        chk("in_ready", in_ready, er);
        chk("in_ready16", in_ready16, er);
        chk("out_valid", out_valid, ev);
        chk("out_valid16", out_valid16, ev);
        chk("done", done, m_done);
        chk("done16", done16, m_done);
        if (ev) begin
            chk("out_row", out_row, m_row);
            chk("out_last", out_last, m_row == R - 1);
            chk("out_last16", out_last16, m_row == R - 1);
            for (int j = 0; j < C; j++) begin
                chk("out_data", out_data[j*AW +: AW], trunc(mc[m_row][j], AW));
                chk("out_data16", out_data16[j*AW2 +: AW2], trunc(mc[m_row][j], AW2));
            end
        end else begin
            chk("idle_last", out_last, 1'b0);
        end
        if (m_post_rst) begin
            chk("rst_out_row", out_row, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_data16", out_data16, 0);
        end
        if (out_valid && first_valid_c < 0) first_valid_c = m_c;
        if (done) done_c = m_c;
        if (out_valid && out_ready) begin
            for (int j = 0; j < C; j++) begin
                obs[out_row][j]   = out_data[j*AW +: AW];
                obs16[out_row][j] = out_data16[j*AW2 +: AW2];
            end
            obs_cnt[out_row]++;
        end
        m_done = 1'b0;
        if (!rst) begin
            m_active   = 1'b0;
            m_post_rst = 1'b1;
        end else if (m_active) begin
            if (ev && out_ready) begin
                if (m_row == R - 1) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else begin
                    m_row++;
                end
            end
        end else if (start) begin
            m_active      = 1'b1;
            m_post_rst    = 1'b0;
            m_c           = 0;
            m_row         = 0;
            m_drain       = (j_k == 0) ? 1 : j_l + R + C;
            first_valid_c = -1;
            done_c        = -1;
            for (int i = 0; i < R; i++) begin
                obs_cnt[i] = 0;
                for (int j = 0; j < C; j++) begin
                    obs[i][j]   = '1;
                    obs16[i][j] = '1;
                end
            end
        end
        m_c++;
    end

    task automatic drive_ready();
        start = 1'b0;
        if (bp_mode == 0) begin
            out_ready = 1'b1;
        end else if (bp_mode == 1) begin
            if (m_active && m_c >= m_drain && m_row == 1 && held < 3) begin
                out_ready = 1'b0;
                held++;
            end else begin
                out_ready = 1'b1;
            end
            if (m_active && m_c >= m_drain && m_row == 2 && !start_pulsed) begin
                start        = 1'b1;
                k_len        = KW'(3);
                start_pulsed = 1'b1;
            end
        end else begin
            out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run_job(input int k, input bit s, input bit gaps, input int abort_beat);
        bit pat[$];
        int ones = 0, beat = 0, n = 0;
        while (ones < k) begin
            if (gaps && $urandom_range(0, 2) == 0) pat.push_back(1'b0);
            else begin
                pat.push_back(1'b1);
                ones++;
            end
        end
        compute_model(k, s);
        held = 0;
        start_pulsed = 1'b0;
        @(posedge clk); #1;
        j_k = k; j_l = pat.size();
        k_len = KW'(k); signed_mode = s; start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; k_len = KW'($urandom); signed_mode = 1'($urandom);
        foreach (pat[p]) begin
            in_valid = pat[p];
            if (pat[p]) begin
                for (int i = 0; i < R; i++) a_data[i*DW +: DW] = DW'(ma[i][beat]);
                for (int j = 0; j < C; j++) b_data[j*DW +: DW] = DW'(mb[beat][j]);
                if (beat == abort_beat) rst = 1'b0;
                beat++;
            end else begin
                a_data = $urandom;
                b_data = $urandom;
            end
            drive_ready();
            @(posedge clk); #1;
            if (!rst) begin
                rst = 1'b1;
                in_valid = 1'b0;
                return;
            end
        end
        while (m_active && n < 1000) begin
            in_valid = 1'($urandom);
            a_data = $urandom;
            b_data = $urandom;
            drive_ready();
            @(posedge clk); #1;
            n++;
        end
        chk("job_completes", m_active, 1'b0);
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic fill(input int av, input int bv);
        for (int i = 0; i < R; i++) for (int k = 0; k < KMAX; k++) ma[i][k] = av;
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < C; j++) mb[k][j] = bv;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < R; i++) for (int k = 0; k < KMAX; k++) ma[i][k] = $urandom_range(0, 255);
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < C; j++) mb[k][j] = $urandom_range(0, 255);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Identity A, B[k][j] = 4k+j: rows equal B; first row at K+R+C = 12, done four rows later.
        for (int i = 0; i < R; i++) for (int k = 0; k < KMAX; k++) ma[i][k] = (i == k) ? 1 : 0;
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < C; j++) mb[k][j] = 4 * k + j;
        run_job(4, 1'b0, 1'b0, -1);
        chk("ident_first_valid", first_valid_c, 12);
        chk("ident_done_cycle", done_c, 16);
        for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) chk("ident_row", obs[i][j], 4 * i + j);

        fill(128, 128);
        run_job(1, 1'b1, 1'b0, -1);
        chk("neg128_signed", obs[0][0], 16384);
        chk("neg128_signed16", obs16[3][2], 16384);
        run_job(1, 1'b0, 1'b0, -1);
        chk("pos128_unsigned", obs[2][1], 16384);
        fill(255, 2);
        run_job(1, 1'b0, 1'b0, -1);
        chk("ff_x2_unsigned", obs[1][3], 510);
        run_job(1, 1'b1, 1'b0, -1);
        chk("ff_x2_signed", obs[1][1], 32'hFFFF_FFFE);
        chk("ff_x2_signed16", obs16[0][2], 16'hFFFE);

        // Bubbles and random drain readiness; latency must grow by exactly the idle feed cycles.
        bp_mode = 2;
        for (int t = 0; t < 4; t++) begin
            fill_rand();
            run_job(7, 1'($urandom), 1'b1, -1);
            chk("bubble_latency", first_valid_c, 7 + R + C + (j_l - 7));
        end
        bp_mode = 0;

        run_job(0, 1'b0, 1'b0, -1);
        chk("k0_first_valid", first_valid_c, 1);
        for (int i = 0; i < R; i++) begin
            chk("k0_row_count", obs_cnt[i], 1);
            for (int j = 0; j < C; j++) chk("k0_zero", obs[i][j], 0);
        end

        bp_mode = 1;
        fill_rand();
        run_job(3, 1'b0, 1'b0, -1);
        for (int i = 0; i < R; i++) chk("bp_row_count", obs_cnt[i], 1);
        bp_mode = 0;

        fill_rand();
        run_job(4, 1'b0, 1'b0, 1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b0);
        chk("abort_done", done, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        fill(2, 3);
        run_job(1, 1'b0, 1'b0, -1);
        for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) chk("after_abort", obs[i][j], 6);

        fill(255, 255);
        run_job(2, 1'b0, 1'b0, -1);
        chk("wrap16", obs16[0][0], 64514);
        chk("wrap16_last", obs16[3][3], 64514);
        chk("nowrap32", obs[2][2], 130050);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
